mul_norm_scheduler: RTL and testbench
=====================================

# mul_norm_scheduler

Iterative normalization scheduler for the FPU_MUL product path. It shares one 8-bit leading-one/position detector between two multiplier requesters. For each request it scans a DATA_W-bit mantissa one byte per cycle, MSB byte first, and returns the leading-zero count, the left-normalized mantissa and a zero flag. It sits between the butterfly multipliers and the exponent-adjust stage of the FFT datapath.

## Interface
- DATA_W, 24, mantissa width; must be a multiple of 8 and at least 8. NUM_CHUNK = DATA_W/8.
- LZC_W, $clog2(DATA_W+1), width of the leading-zero count.
- i_clk  in  1  single clock; all state updates on the rising edge.
- i_rst_n  in  1  reset, synchronous and active-low.
- i_req0_valid  in  1  requester 0 has a mantissa.
- i_req0_data  in  DATA_W  requester 0 mantissa.
- o_req0_ready  out  1  requester 0 accepted this cycle (valid & ready).
- i_req1_valid / i_req1_data / o_req1_ready: same as requester 0, for requester 1.
- o_res_valid  out  1  result held.
- i_res_ready  in  1  consumer accepts the result.
- o_res_id  out  1  requester that owns the result.
- o_res_lzc  out  LZC_W  leading zeros of the mantissa (DATA_W when zero).
- o_res_data  out  DATA_W  mantissa << lzc, truncated to DATA_W bits (0 when zero).
- o_res_zero  out  1  mantissa was all zero.
- o_busy  out  1  state is not IDLE.

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - Round-robin arbiter with a 1-bit priority pointer; pointer resets to 0.
  - Grant goes to the pointer's requester if valid, else to the other requester if valid.
  - Only the granted o_reqN_ready is high, combinationally, and only in IDLE and while i_rst_n=1.
  - On grant: latch data and id, clear the chunk index k and the lzc accumulator, set pointer = ~granted id, go to SCAN.
- SCAN, chunk k (0 = MSB byte) = data[DATA_W-1-8k -: 8]:
  - Detector semantics: pos = leading zeros in the byte (bit7 set gives 0, bit0 only gives 7); zero = byte is 0x00.
  - Byte nonzero: lzc = 8k + pos, zero = 0, data_out = data << lzc. Go to DONE.
  - Byte zero and k < NUM_CHUNK-1: k++, stay in SCAN.
  - Byte zero and k = NUM_CHUNK-1: lzc = DATA_W, zero = 1, data_out = 0. Go to DONE.
- DONE:
  - o_res_valid = 1; all result outputs stay stable until i_res_valid & i_res_ready. Go to IDLE on that handshake.
  - No request is accepted in DONE or SCAN; ready is low in both.
- Arithmetic: lzc and the shift are computed in LZC_W bits and DATA_W bits respectively; no overflow is possible.
- Reset values: o_res_valid 0, o_res_id 0, o_res_lzc 0, o_res_data 0, o_res_zero 0, o_busy 0, readies 0, pointer 0, state IDLE.

## Timing
- Accept edge is A, the rising edge where valid & ready.
- SCAN occupies cycles A+1 .. A+c, where c is the number of chunks scanned (1..NUM_CHUNK).
- o_res_valid rises in cycle A+c+1.
- Latency from accept to result is therefore c+1 cycles: min 2 (leading one in the MSB byte), max NUM_CHUNK+1 (4 for DATA_W=24).
- Back-to-back operation: the result handshake in DONE returns the FSM to IDLE next cycle, and the next grant can occur in that IDLE cycle. Minimum period is c+2 cycles.
- Simultaneous valid on both requesters: the pointer decides; the pointer flips on every grant. A requester's valid dropped without ready is ignored; there is no stored request.
- Held backpressure (i_res_ready low): stay in DONE indefinitely; outputs and o_busy stay constant.
- Reset mid-SCAN or mid-DONE: on the edge with i_rst_n=0, go to IDLE with all outputs at reset values. The in-flight operation is discarded and no result is emitted. Readies stay low during every reset cycle.
- Input data is sampled only at the accept edge; later changes on i_reqN_data have no effect.

## Test plan
- Reset, then req0 data 24'h800000, i_res_ready=1 -> o_res_valid in A+2: lzc 0, data 24'h800000, zero 0, id 0.
- Req1 data 24'h000180 -> two SCAN cycles, valid in A+3: lzc 15, data 24'hC00000, zero 0, id 1.
- Req0 data 24'h000000 -> valid in A+4: lzc 24, data 0, zero 1.
- Both requesters valid continuously after reset, data 24'h400000 and 24'h000001 -> grants alternate id 0,1,0,1. Results are lzc 1 / data 24'h800000 and lzc 23 / data 24'h800000. Readies are never high together.
- Result pending with i_res_ready low for 5 cycles -> outputs stable, o_busy 1, readies 0. Raise ready -> IDLE next cycle, then a new grant.
- Assert i_rst_n=0 for one cycle during SCAN of 24'h000001 -> o_res_valid never rises for that operation; pointer is 0 and outputs are at reset values after the reset edge.

Source files
------------

// File: rtl/mul_norm_scheduler.sv
// Shared byte-serial leading-one normalizer for two multiplier requesters.
// Scans one mantissa byte per cycle (MSB first) and returns lzc, normalized mantissa and a zero flag.
module mul_norm_scheduler #(
  parameter int DATA_W = 24,
  parameter int LZC_W  = $clog2(DATA_W + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req0_valid,
  input  logic [DATA_W-1:0] i_req0_data,
  output logic              o_req0_ready,
  input  logic              i_req1_valid,
  input  logic [DATA_W-1:0] i_req1_data,
  output logic              o_req1_ready,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic              o_res_id,
  output logic [LZC_W-1:0]  o_res_lzc,
  output logic [DATA_W-1:0] o_res_data,
  output logic              o_res_zero,
  output logic              o_busy,
  output logic [1:0]        o_dbg_state
);

  localparam int NUM_CHUNK = DATA_W / 8;
  localparam int KW        = (NUM_CHUNK > 1) ? $clog2(NUM_CHUNK) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Handshakes: a request transfers on the rising edge where i_reqN_valid & o_reqN_ready;
  // a result transfers on the rising edge where o_res_valid & i_res_ready. Neither side
  // may depend on the other's ready to raise valid.

  state_t            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              id_q, id_d;
  logic [KW-1:0]     k_q, k_d;
  logic [LZC_W-1:0]  res_lzc_q, res_lzc_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              res_zero_q, res_zero_d;

  logic              gnt0, gnt1;
  logic [DATA_W-1:0] chunk_sh;
  logic [7:0]        byte_w;
  logic [2:0]        pos;
  logic              byte_zero;
  logic              last_chunk;
  logic [LZC_W-1:0]  lzc_calc;

  // Bring chunk k to the top so the detector always looks at the same 8 bits.
  assign chunk_sh   = data_q << {k_q, 3'b000};
  assign byte_w     = chunk_sh[DATA_W-1 -: 8];
  assign byte_zero  = (byte_w == 8'd0);
  assign last_chunk = (k_q == KW'(NUM_CHUNK - 1));
  assign lzc_calc   = LZC_W'({k_q, 3'b000}) + LZC_W'(pos);

  always_comb begin
    pos = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (byte_w[i]) pos = 3'(7 - i);
    end
  end

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == ST_IDLE && i_rst_n) begin
      if (!ptr_q) begin
        gnt0 = i_req0_valid;
        gnt1 = i_req1_valid & ~i_req0_valid;
      end else begin
        gnt1 = i_req1_valid;
        gnt0 = i_req0_valid & ~i_req1_valid;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    data_d     = data_q;
    id_d       = id_q;
    k_d        = k_q;
    res_lzc_d  = res_lzc_q;
    res_data_d = res_data_q;
    res_zero_d = res_zero_q;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt0 || gnt1) begin
          data_d  = gnt1 ? i_req1_data : i_req0_data;
          id_d    = gnt1;
          k_d     = '0;
          ptr_d   = ~gnt1;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (!byte_zero) begin
          res_lzc_d  = lzc_calc;
          res_data_d = data_q << lzc_calc;
          res_zero_d = 1'b0;
          state_d    = ST_DONE;
        end else if (last_chunk) begin
          res_lzc_d  = LZC_W'(DATA_W);
          res_data_d = '0;
          res_zero_d = 1'b1;
          state_d    = ST_DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      ST_DONE: begin
        if (i_res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= 1'b0;
      data_q     <= '0;
      id_q       <= 1'b0;
      k_q        <= '0;
      res_lzc_q  <= '0;
      res_data_q <= '0;
      res_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      data_q     <= data_d;
      id_q       <= id_d;
      k_q        <= k_d;
      res_lzc_q  <= res_lzc_d;
      res_data_q <= res_data_d;
      res_zero_q <= res_zero_d;
    end
  end

  assign o_req0_ready = gnt0;
  assign o_req1_ready = gnt1;
  assign o_res_valid  = (state_q == ST_DONE);
  assign o_res_id     = id_q;
  assign o_res_lzc    = res_lzc_q;
  assign o_res_data   = res_data_q;
  assign o_res_zero   = res_zero_q;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_mul_norm_scheduler.sv
// Bench for mul_norm_scheduler: vector table through a result scoreboard, plus
// arbitration, backpressure and mid-scan reset sequences.
module tb_mul_norm_scheduler;

  localparam int DATA_W = 24;
  localparam int LZC_W  = 5;
  localparam int RW     = 1 + 1 + LZC_W + DATA_W;

  logic              clk;
  logic              rst_n;
  logic              req0_valid, req1_valid;
  logic [DATA_W-1:0] req0_data, req1_data;
  logic              req0_ready, req1_ready;
  logic              res_valid, res_ready;
  logic              res_id, res_zero, busy;
  logic [LZC_W-1:0]  res_lzc;
  logic [DATA_W-1:0] res_data;
  logic [1:0]        dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [RW-1:0] exp_q[$];

  typedef struct {
    logic              id;
    logic [DATA_W-1:0] d;
    logic [LZC_W-1:0]  lzc;
    logic [DATA_W-1:0] od;
    logic              z;
    int                lat;
  } vec_t;
  vec_t tbl[9];

  mul_norm_scheduler #(.DATA_W(DATA_W), .LZC_W(LZC_W)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req0_valid (req0_valid),
    .i_req0_data  (req0_data),
    .o_req0_ready (req0_ready),
    .i_req1_valid (req1_valid),
    .i_req1_data  (req1_data),
    .o_req1_ready (req1_ready),
    .o_res_valid  (res_valid),
    .i_res_ready  (res_ready),
    .o_res_id     (res_id),
    .o_res_lzc    (res_lzc),
    .o_res_data   (res_data),
    .o_res_zero   (res_zero),
    .o_busy       (busy),
    .o_dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // scoreboard: results are compared when the result handshake is about to occur
  always begin
    @(negedge clk);
    #3;
    chk("ready_onehot", {31'd0, req0_ready & req1_ready}, 32'd0);
    chk("ready_when_busy", {31'd0, (req0_ready | req1_ready) & busy}, 32'd0);
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        logic [RW-1:0] e;
        e = exp_q.pop_front();
        chk("result", {1'b0, res_id, res_zero, res_lzc, res_data}, {1'b0, e});
      end
    end
  end

  // driver: present one request, push its expectation at accept, measure latency
  task automatic send(input logic id, input logic [DATA_W-1:0] d, input logic [LZC_W-1:0] lzc,
                      input logic [DATA_W-1:0] od, input logic z, input int lat);
    bit got;
    int n;
    @(negedge clk);
    if (id) begin req1_valid = 1'b1; req1_data = d; end
    else    begin req0_valid = 1'b1; req0_data = d; end
    got = 1'b0;
    for (int t = 0; t < 20; t++) begin
      #1;
      if ((id ? req1_ready : req0_ready) === 1'b1) begin got = 1'b1; break; end
      @(negedge clk);
    end
    chk("accept_timeout", {31'd0, got}, 32'd1);
    if (!got) begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      return;
    end
    exp_q.push_back({id, z, lzc, od});
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data  = 24'($urandom);
    req1_data  = 24'($urandom);
    got = 1'b0;
    n   = 0;
    for (int e = 1; e <= 20; e++) begin
      @(negedge clk);
      #1;
      if (res_valid) begin got = 1'b1; n = e; break; end
    end
    chk("result_timeout", {31'd0, got}, 32'd1);
    if (got) chk("latency", n, lat);
  endtask

  task automatic drain();
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && !res_valid) break;
    end
    chk("drain", exp_q.size(), 32'd0);
  endtask

  initial begin
    int exp_id;
    int grants;

    tbl[0] = '{1'b0, 24'h800000, 5'd0,  24'h800000, 1'b0, 2};
    tbl[1] = '{1'b1, 24'h000180, 5'd15, 24'hC00000, 1'b0, 3};
    tbl[2] = '{1'b0, 24'h000000, 5'd24, 24'h000000, 1'b1, 4};
    tbl[3] = '{1'b1, 24'h000001, 5'd23, 24'h800000, 1'b0, 4};
    tbl[4] = '{1'b0, 24'h00FF00, 5'd8,  24'hFF0000, 1'b0, 3};
    tbl[5] = '{1'b1, 24'h123456, 5'd3,  24'h91A2B0, 1'b0, 2};
    tbl[6] = '{1'b0, 24'h0000A5, 5'd16, 24'hA50000, 1'b0, 4};
    tbl[7] = '{1'b1, 24'h7FFFFF, 5'd1,  24'hFFFFFE, 1'b0, 2};
    tbl[8] = '{1'b0, 24'h001000, 5'd11, 24'h800000, 1'b0, 3};

    rst_n      = 1'b0;
    req0_valid = 1'b1;
    req0_data  = 24'h800000;
    req1_valid = 1'b0;
    req1_data  = '0;
    res_ready  = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk("ready_in_reset", {31'd0, req0_ready}, 32'd0);
    req0_valid = 1'b0;
    rst_n      = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res_id",    {31'd0, res_id},    32'd0);
    chk("rst_res_lzc",   {27'd0, res_lzc},   32'd0);
    chk("rst_res_data",  {8'd0, res_data},   32'd0);
    chk("rst_res_zero",  {31'd0, res_zero},  32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_state",     {30'd0, dbg_state}, 32'd0);

    // table vectors
    for (int i = 0; i < 9; i++) begin
      send(tbl[i].id, tbl[i].d, tbl[i].lzc, tbl[i].od, tbl[i].z, tbl[i].lat);
    end
    drain();

    // held backpressure, then grant in the first IDLE cycle
    res_ready = 1'b0;
    send(1'b1, 24'h000180, 5'd15, 24'hC00000, 1'b0, 3);
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      req0_valid = 1'b1;
      req0_data  = 24'h000001;
      req1_valid = 1'b1;
      req1_data  = 24'h000001;
      #1;
      chk("bp_valid",  {31'd0, res_valid}, 32'd1);
      chk("bp_busy",   {31'd0, busy},      32'd1);
      chk("bp_lzc",    {27'd0, res_lzc},   32'd15);
      chk("bp_data",   {8'd0, res_data},   32'h00C00000);
      chk("bp_id",     {31'd0, res_id},    32'd1);
      chk("bp_zero",   {31'd0, res_zero},  32'd0);
      chk("bp_readies", {31'd0, req0_ready | req1_ready}, 32'd0);
      chk("bp_state",  {30'd0, dbg_state}, 32'd2);
    end
    @(negedge clk);
    req1_valid = 1'b0;
    req0_data  = 24'h400000;
    res_ready  = 1'b1;
    @(negedge clk);
    #1;
    chk("idle_busy",  {31'd0, busy},       32'd0);
    chk("idle_grant", {31'd0, req0_ready}, 32'd1);
    if (req0_ready) exp_q.push_back({1'b0, 1'b0, 5'd1, 24'h800000});
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    drain();

    // both requesters continuously valid: grants alternate from id 0
    do_reset();
    req0_valid = 1'b1;
    req0_data  = 24'h400000;
    req1_valid = 1'b1;
    req1_data  = 24'h000001;
    exp_id = 0;
    grants = 0;
    for (int t = 0; t < 100; t++) begin
      #1;
      if (req0_ready || req1_ready) begin
        chk("grant_id", {31'd0, req1_ready}, exp_id);
        if (exp_id == 0) exp_q.push_back({1'b0, 1'b0, 5'd1,  24'h800000});
        else             exp_q.push_back({1'b1, 1'b0, 5'd23, 24'h800000});
        exp_id = 1 - exp_id;
        grants++;
        if (grants == 4) begin
          @(posedge clk);
          #1;
          req0_valid = 1'b0;
          req1_valid = 1'b0;
          break;
        end
      end
      @(negedge clk);
    end
    chk("fair_grants", grants, 32'd4);
    drain();

    // reset during SCAN discards the operation
    do_reset();
    req0_valid = 1'b1;
    req0_data  = 24'h000001;
    #1;
    chk("mid_accept", {31'd0, req0_ready}, 32'd1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_state_scan", {30'd0, dbg_state}, 32'd1);
    rst_n      = 1'b0;
    req1_valid = 1'b1;
    req1_data  = 24'h800000;
    @(negedge clk);
    #1;
    chk("mid_rst_ready",  {31'd0, req1_ready}, 32'd0);
    chk("mid_rst_valid",  {31'd0, res_valid},  32'd0);
    chk("mid_rst_busy",   {31'd0, busy},       32'd0);
    chk("mid_rst_lzc",    {27'd0, res_lzc},    32'd0);
    chk("mid_rst_data",   {8'd0, res_data},    32'd0);
    chk("mid_rst_zero",   {31'd0, res_zero},   32'd0);
    chk("mid_rst_id",     {31'd0, res_id},     32'd0);
    rst_n      = 1'b1;
    req1_valid = 1'b0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      #1;
      chk("mid_no_result", {31'd0, res_valid}, 32'd0);
    end
    @(negedge clk);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("mid_ptr_r0", {31'd0, req0_ready}, 32'd1);
    chk("mid_ptr_r1", {31'd0, req1_ready}, 32'd0);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (3) @(negedge clk);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
